// File: rtl/bracket_sequence_unranker.sv
// bracket_sequence_unranker
//
// Decodes an index k in [0, C_N) into the k-th proper bracket sequence of
// length 2N in lexicographic order ('(' before ')'). The sequence is streamed
// one symbol per valid/ready handshake. An out-of-range index is rejected
// with a one-cycle err pulse.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   in_valid_i   index offered
//   in_ready_o   idle and able to accept an index
//   in_index_i   requested index k (W bits)
//   out_valid_o  out_bit_o is valid
//   out_ready_i  consumer accepts out_bit_o
//   out_bit_o    0 = '(' , 1 = ')'
//   out_last_o   marks symbol 2N of a sequence
//   err_o        one-cycle pulse when an index is rejected
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an index, in_ready_o high
// CHECK | one cycle: compare latched index against C_N
// EMIT  | streaming symbols, one per handshake, until r reaches 0

module bracket_sequence_unranker #(
    parameter int N = 10,
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_index_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         out_bit_o,
    output logic         out_last_o,
    output logic         err_o
);

    // Table P(r,d): rows r = 0..2N, columns d = 0..N+1. Column N+1 is kept
    // all-zero so that the lookup P(r-1, d+1) never needs a range check.
    localparam int COLS     = N + 2;
    localparam int ROWS     = 2 * N + 1;
    localparam int TBL_BITS = ROWS * COLS * W;
    localparam int IW       = $clog2(TBL_BITS);
    localparam int RW       = $clog2(2 * N + 1);

    function automatic logic [TBL_BITS-1:0] build_table();
        logic [TBL_BITS-1:0] t;
        logic [W-1:0]        up;
        logic [W-1:0]        dn;
        t        = '0;
        t[0 +: W] = W'(1);
        for (int r = 1; r < ROWS; r++) begin
            for (int d = 0; d <= N; d++) begin
                dn = (d > 0) ? t[((r - 1) * COLS + d - 1) * W +: W] : '0;
                up = t[((r - 1) * COLS + d + 1) * W +: W];
                t[(r * COLS + d) * W +: W] = up + dn;
            end
        end
        return t;
    endfunction

    localparam logic [TBL_BITS-1:0] TABLE   = build_table();
    localparam logic [W-1:0]        CATALAN = TABLE[(2 * N * COLS) * W +: W];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  k_q, k_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [RW-1:0] depth_q, depth_d;
    logic          err_q, err_d;

    // c = P(r-1, d+1): number of completions if the next symbol is '('.
    logic [31:0]   tbl_idx;
    logic [IW-1:0] bit_base;
    logic [W-1:0]  c_w;
    logic          take_close;

    always_comb begin
        tbl_idx = '0;
        if (rem_q != '0) begin
            tbl_idx = (32'(rem_q) - 32'd1) * 32'(COLS) + 32'(depth_q) + 32'd1;
        end
    end

    assign bit_base   = IW'(tbl_idx * 32'(W));
    assign c_w        = TABLE[bit_base +: W];
    assign take_close = (k_q >= c_w);

    assign in_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign out_valid_o = (state_q == S_EMIT);
    assign out_bit_o   = out_valid_o && take_close;
    assign out_last_o  = out_valid_o && (rem_q == RW'(1));
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rem_d   = rem_q;
        depth_d = depth_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    k_d     = in_index_i;
                    rem_d   = RW'(2 * N);
                    depth_d = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (k_q >= CATALAN) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready_i) begin
                    rem_d = rem_q - RW'(1);
                    if (take_close) begin
                        // Skip all sequences that put '(' here.
                        k_d     = k_q - c_w;
                        depth_d = depth_q - RW'(1);
                    end else begin
                        depth_d = depth_q + RW'(1);
                    end
                    if (rem_q == RW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            rem_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rem_q   <= rem_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bracket_sequence_unranker.sv
// Bench for bracket_sequence_unranker with three instances (N = 3, 4, 10).
// The reference enumerates bracket strings as bit patterns in increasing
// numeric order ('(' = 0), which is exactly lexicographic order.
module tb_bracket_sequence_unranker;

    localparam int W  = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [W-1:0] in_index  [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic         out_bit   [NI];
    logic         out_last  [NI];
    logic         err       [NI];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          rand_rdy = 1'b0;
    int unsigned cat_m  [NI];
    int          hs_cnt [NI];
    int          err_cnt = 0;
    int          err_cyc = 0;
    logic [31:0] cap_q [$];

    function automatic int nsz(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 4 : 10);
    endfunction

    function automatic bit proper(input int unsigned m, input int n);
        int dep;
        dep = 0;
        for (int p = 2 * n - 1; p >= 0; p--) begin
            dep += m[p] ? -1 : 1;
            if (dep < 0) return 1'b0;
        end
        return dep == 0;
    endfunction

    function automatic int unsigned count_ref(input int n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned m = 0; m < (32'd1 << (2 * n)); m++)
            if (proper(m, n)) cnt++;
        return cnt;
    endfunction

    function automatic int unsigned unrank_ref(input int n, input int unsigned k);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned m = 0; m < (32'd1 << (2 * n)); m++) begin
            if (proper(m, n)) begin
                if (cnt == k) return m;
                cnt++;
            end
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NN = (g == 0) ? 3 : ((g == 1) ? 4 : 10);
        bracket_sequence_unranker #(.N(NN), .W(W)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .in_index_i  (in_index[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .out_bit_o   (out_bit[g]),
            .out_last_o  (out_last[g]),
            .err_o       (err[g])
        );

        // Reference: phase 0 waiting, 1 index being judged, 2 streaming.
        int          st    = 0;
        int unsigned mk    = 0;
        int unsigned mmask = 0;
        int          pos   = 0;
        bit          errf  = 1'b0;
        int          dep   = 0;
        int unsigned cap   = 0;

        always @(negedge clk) begin
            if (rst) begin
                chk("in_ready_during_rst", in_ready[g], 1'b0);
                st = 0; errf = 1'b0; pos = 0; dep = 0; cap = 0;
            end else begin
                chk("in_ready", in_ready[g], st == 0);
                chk("out_valid", out_valid[g], st == 2);
                chk("err", err[g], errf);
                if (err[g]) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                if (st == 2) begin
                    chk("out_bit", out_bit[g], mmask[2 * NN - 1 - pos]);
                    chk("out_last", out_last[g], pos == 2 * NN - 1);
                end else begin
                    chk("bit_last_when_invalid", {out_bit[g], out_last[g]}, 2'b00);
                end
                errf = 1'b0;
                case (st)
                    0: if (in_valid[g]) begin
                        mk = in_index[g];
                        st = 1;
                    end
                    1: if (mk >= cat_m[g]) begin
                        errf = 1'b1;
                        st   = 0;
                    end else begin
                        mmask = unrank_ref(NN, mk);
                        pos = 0; dep = 0; cap = 0;
                        st = 2;
                    end
                    2: if (out_ready[g]) begin
                        cap = (cap << 1) | 32'(out_bit[g]);
                        dep += out_bit[g] ? -1 : 1;
                        chk("depth_bounds", (dep >= 0) && (dep <= 2 * NN - 1 - pos), 1'b1);
                        hs_cnt[g]++;
                        pos++;
                        if (pos == 2 * NN) begin
                            cap_q.push_back(cap);
                            st = 0;
                        end
                    end
                    default: st = 0;
                endcase
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++)
            out_ready[i] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input int i, input int unsigned idx, output int hs);
        bit ok;
        ok = 1'b0;
        in_index[i] = idx;
        in_valid[i] = 1'b1;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk);
            if (in_ready[i]) ok = 1'b1;
        end
        #1;
        in_valid[i] = 1'b0;
        hs = cyc - 1;
        chk("index_handshake", ok, 1'b1);
    endtask

    task automatic drain(input int i);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (in_ready[i]) ok = 1'b1;
        end
        chk("return_to_idle", ok, 1'b1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hs;
        int          hsa [5];
        int          e0;
        int          h0;
        int          ii;
        int unsigned kk;
        int unsigned exp3 [5];
        bit          reached;

        exp3[0] = 32'b000111;
        exp3[1] = 32'b001011;
        exp3[2] = 32'b001101;
        exp3[3] = 32'b010011;
        exp3[4] = 32'b010101;

        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0;
            in_index[i] = '0;
            hs_cnt[i]   = 0;
            cat_m[i]    = count_ref(nsz(i));
        end

        chk("ref_catalan_3", cat_m[0], 5);
        chk("ref_catalan_4", cat_m[1], 14);
        chk("ref_catalan_10", cat_m[2], 16796);
        chk("ref_unrank_3_2", unrank_ref(3, 2), 32'b001101);
        chk("ref_unrank_10_0", unrank_ref(10, 0), 32'h0003FF);
        chk("ref_unrank_10_last", unrank_ref(10, 16795), 32'h055555);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // N=3, indices 0..4 back-to-back
        cap_q.delete();
        for (int k = 0; k < 5; k++) send(0, k, hsa[k]);
        drain(0);
        chk("n3_seq_count", cap_q.size(), 5);
        for (int k = 0; k < 5; k++) chk("n3_seq", cap_q[k], exp3[k]);
        for (int k = 1; k < 5; k++) chk("n3_period", hsa[k] - hsa[k-1], 8);

        // N=3, index 5 rejected, then index 0
        cap_q.delete();
        e0 = err_cnt;
        send(0, 5, hs);
        repeat (4) @(negedge clk);
        chk("n3_err_count", err_cnt - e0, 1);
        chk("n3_err_latency", err_cyc - hs, 2);
        chk("n3_err_no_output", cap_q.size(), 0);
        send(0, 0, hs);
        drain(0);
        chk("n3_after_err", cap_q[0], 32'b000111);

        // N=10 boundaries
        cap_q.delete();
        send(2, 0, hs);
        drain(2);
        send(2, 16795, hs);
        drain(2);
        e0 = err_cnt;
        send(2, 16796, hs);
        repeat (4) @(negedge clk);
        chk("n10_first", cap_q[0], 32'h0003FF);
        chk("n10_last", cap_q[1], 32'h055555);
        chk("n10_err", err_cnt - e0, 1);

        // N=3, index 2 under random backpressure
        rand_rdy = 1'b1;
        cap_q.delete();
        send(0, 2, hs);
        drain(0);
        chk("n3_stall_seq", cap_q[0], 32'b001101);
        rand_rdy = 1'b0;

        // N=3, reset after third symbol of index 4
        @(posedge clk);
        #2;
        cap_q.delete();
        e0 = err_cnt;
        h0 = hs_cnt[0];
        send(0, 4, hs);
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge clk);
            if (hs_cnt[0] >= h0 + 3) reached = 1'b1;
        end
        chk("rst_third_symbol_reached", reached, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid[0], 1'b0);
        chk("rst_in_ready", in_ready[0], 1'b1);
        chk("rst_no_last", cap_q.size(), 0);
        chk("rst_no_err", err_cnt - e0, 0);
        send(0, 1, hs);
        drain(0);
        chk("after_rst_seq", cap_q[0], 32'b001011);

        // N=4, all indices
        cap_q.delete();
        for (int k = 0; k < 14; k++) send(1, k, hs);
        drain(1);
        chk("n4_count", cap_q.size(), 14);
        for (int k = 0; k < 14; k++) chk("n4_proper", proper(cap_q[k], 4), 1'b1);
        for (int k = 1; k < 14; k++) chk("n4_increasing", cap_q[k] > cap_q[k-1], 1'b1);
        e0 = err_cnt;
        send(1, 14, hs);
        repeat (4) @(negedge clk);
        chk("n4_err", err_cnt - e0, 1);

        // Random indices, random backpressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 24; t++) begin
            ii = $urandom_range(0, NI - 1);
            kk = $urandom_range(0, cat_m[ii] + 1);
            if ($urandom_range(0, 3) == 0) kk = cat_m[ii] - 1;
            send(ii, kk, hs);
            drain(ii);
        end
        rand_rdy = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
